// File: rtl/gps_uart_tx.sv
// ============================================================================
// gps_uart_tx : FIFO-buffered 8-bit UART transmitter with pad tristate control
// Optional even parity bit enabled by defining GPS_UART_TX_PARITY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gps_uart_tx #(
  parameter int unsigned BAUD_DIV = 10417,
  parameter int unsigned DEPTH    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_ena,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       clr_ovf,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       ovf,
  output logic       txd_o,
  output logic       txd_t
);

  localparam int unsigned C_AW     = $clog2(DEPTH);
  localparam int unsigned C_CW     = C_AW + 1;
  localparam logic [15:0] C_RELOAD = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef GPS_UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  logic [7:0]      mem_q [DEPTH];
  logic [C_AW-1:0] wptr_q, rptr_q;
  logic [C_CW-1:0] count_q, count_d;
  logic            full_q, empty_q, ovf_q, ovf_d;
  logic            push, pop, start;
  logic [7:0]      head;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            txd_q, txd_d;
  logic            busy_q, txd_t_q, busy_d;
`ifdef GPS_UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  assign head = mem_q[rptr_q];
  // A pop frees a slot in the same cycle, so a write to a full FIFO still lands.
  assign push = wr && (!full_q || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  assign ovf_d = (ovf_q && !clr_ovf) || (wr && full_q && !pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == C_CW'(DEPTH));
      empty_q <= (count_d == '0);
      ovf_q   <= ovf_d;
    end
  end

  assign start = tx_ena && !empty_q &&
                 ((state_q == S_IDLE) || (state_q == S_STOP && cnt_q == '0));
  assign pop   = start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
`ifdef GPS_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        cnt_d = '0;
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = C_RELOAD;
          bit_d   = 3'd0;
          txd_d   = sh_q[0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = C_RELOAD;
          if (bit_q == 3'd7) begin
`ifdef GPS_UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = {1'b0, sh_q[7:1]};
            txd_d = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef GPS_UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_d = S_STOP;
          cnt_d   = C_RELOAD;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase

    // Frame launch from IDLE or straight out of the last stop cycle.
    if (start) begin
      state_d = S_START;
      cnt_d   = C_RELOAD;
      sh_d    = head;
      txd_d   = 1'b0;
`ifdef GPS_UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      txd_t_q <= 1'b1;
`ifdef GPS_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      txd_t_q <= !(tx_ena || busy_d);
`ifdef GPS_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign busy  = busy_q;
  assign ovf   = ovf_q;
  assign txd_o = txd_q;
  assign txd_t = txd_t_q;

endmodule

`default_nettype wire

// File: tb/tb_gps_uart_tx.sv
// ============================================================================
// tb_gps_uart_tx : scoreboard bench for gps_uart_tx (BAUD_DIV=4, DEPTH=8)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gps_uart_tx;

  localparam int BAUD = 4;
`ifdef GPS_UART_TX_PARITY_EN
  localparam int FR = 11;
`else
  localparam int FR = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_ena = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       full, empty, busy, ovf, txd_o, txd_t;

  gps_uart_tx #(.BAUD_DIV(BAUD), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .tx_ena(tx_ena), .wr(wr), .wdata(wdata),
    .clr_ovf(clr_ovf), .full(full), .empty(empty), .busy(busy), .ovf(ovf),
    .txd_o(txd_o), .txd_t(txd_t)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic par; } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int frames_seen = 0;

  logic        m_active = 1'b0;
  exp_t        m_exp;
  logic [10:0] m_bits;
  int          m_pos, m_cyc;
  logic        m_bad;
  logic [1:0]  m_got;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d);
    exp_t e;
    e.data = d;
    e.par  = ^d;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(busy === 1'b0 && empty === 1'b1) && n < 3000) begin
      tick();
      n++;
    end
    check(name, 32'(n < 3000), 32'd1);
  endtask

  // Receiver: checks every cycle of every bit against the expected frame.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        m_active = 1'b0;
      end else begin
        if (!m_active && txd_o === 1'b0) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got start bit, required none at %0t", $time);
            m_exp.data = 8'h00;
            m_exp.par  = 1'b0;
          end else begin
            m_exp = sb.pop_front();
          end
          m_bits      = '1;
          m_bits[0]   = 1'b0;
          m_bits[8:1] = m_exp.data;
`ifdef GPS_UART_TX_PARITY_EN
          m_bits[9]   = m_exp.par;
`endif
          m_active = 1'b1;
          m_pos    = 0;
          m_cyc    = 0;
          m_bad    = 1'b0;
          m_got    = 2'b00;
        end
        if (m_active) begin
          if (txd_o !== m_bits[m_pos] || busy !== 1'b1) begin
            m_bad = 1'b1;
            m_got = {busy, txd_o};
          end
          m_cyc++;
          if (m_cyc == BAUD) begin
            vectors++;
            if (m_bad) begin
              miscompares++;
              $display("FAIL frame_bit byte %02h pos %0d: got busy/txd %b required busy/txd 1%b",
                       m_exp.data, m_pos, m_got, m_bits[m_pos]);
            end
            m_cyc = 0;
            m_bad = 1'b0;
            m_pos++;
            if (m_pos == FR) begin
              m_active = 1'b0;
              frames_seen++;
            end
          end
        end
      end
    end
  endtask

  typedef struct { logic [7:0] data; logic exp_par; } vec_t;
  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    exp_t e;

    tbl[0] = '{8'h55, 1'b0};
    tbl[1] = '{8'h80, 1'b1};
    tbl[2] = '{8'h01, 1'b1};
    tbl[3] = '{8'hFF, 1'b0};
    tbl[4] = '{8'h00, 1'b0};
    tbl[5] = '{8'h07, 1'b1};

    fork
      monitor();
    join_none

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_txd_o", 32'(txd_o), 32'd1);
    check("rst_txd_t", 32'(txd_t), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_full",  32'(full),  32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ovf",   32'(ovf),   32'd0);
    rst = 1'b0;
    tx_ena = 1'b1;
    tick();
    tick();
    check("ena_txd_t", 32'(txd_t), 32'd0);

    // Single frames: latency, bit timing, busy length
    for (int i = 0; i < 6; i++) begin
      e.data = tbl[i].data;
      e.par  = tbl[i].exp_par;
      wr = 1'b1;
      wdata = tbl[i].data;
      sb.push_back(e);
      tick();
      wr = 1'b0;
      check("lat_n1_txd", 32'(txd_o), 32'd1);
      check("lat_n1_empty", 32'(empty), 32'd0);
      tick();
      check("lat_n2_txd", 32'(txd_o), 32'd0);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
        n++;
        tick();
      end
      check("busy_len", 32'(n), 32'(FR * BAUD));
      check("idle_txd", 32'(txd_o), 32'd1);
      check("idle_empty", 32'(empty), 32'd1);
    end
    check("sb_after_table", 32'(sb.size()), 32'd0);

    // Back-to-back frames with no gap
    wr = 1'b1; wdata = 8'h80; push_exp(8'h80);
    tick();
    wdata = 8'h01; push_exp(8'h01);
    tick();
    wr = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    check("b2b_busy_len", 32'(n), 32'(2 * FR * BAUD));
    check("b2b_sb", 32'(sb.size()), 32'd0);

    // Overflow with transmitter disabled
    tx_ena = 1'b0;
    tick();
    base = frames_seen;
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1;
      wdata = 8'h10 + 8'(i);
      push_exp(wdata);
      tick();
    end
    wr = 1'b0;
    check("full_after_8", 32'(full), 32'd1);
    check("ovf_before", 32'(ovf), 32'd0);
    wr = 1'b1; wdata = 8'hEE;
    tick();
    wr = 1'b0;
    check("ovf_set", 32'(ovf), 32'd1);
    check("full_kept", 32'(full), 32'd1);
    tick();
    check("ovf_sticky", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);
    clr_ovf = 1'b1; wr = 1'b1; wdata = 8'hEF;
    tick();
    clr_ovf = 1'b0; wr = 1'b0;
    check("ovf_clr_vs_set", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("txd_t_disabled", 32'(txd_t), 32'd1);
    tx_ena = 1'b1;
    wait_idle("drain8_timeout");
    check("drain8_frames", 32'(frames_seen - base), 32'd8);
    check("drain8_sb", 32'(sb.size()), 32'd0);
    check("drain8_empty", 32'(empty), 32'd1);

    // Write while full in the same cycle as a pop
    tx_ena = 1'b0;
    tick();
    base = frames_seen;
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1;
      wdata = 8'hC0 + 8'(i);
      push_exp(wdata);
      tick();
    end
    tx_ena = 1'b1; wdata = 8'h99; push_exp(8'h99);
    tick();
    wr = 1'b0;
    check("wr_pop_full", 32'(full), 32'd1);
    check("wr_pop_ovf", 32'(ovf), 32'd0);
    wait_idle("drain9_timeout");
    check("drain9_frames", 32'(frames_seen - base), 32'd9);

    // tx_ena dropped during data bit 3
    wr = 1'b1; wdata = 8'hA5; push_exp(8'hA5);
    tick();
    wdata = 8'h3C; push_exp(8'h3C);
    tick();
    wr = 1'b0;
    repeat (17) tick();
    tx_ena = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check("drop_txd_o", 32'(txd_o), 32'd1);
    check("drop_txd_t", 32'(txd_t), 32'd1);
    check("drop_empty", 32'(empty), 32'd0);
    repeat (10) tick();
    check("drop_hold_busy", 32'(busy), 32'd0);
    check("drop_sb", 32'(sb.size()), 32'd1);
    tx_ena = 1'b1;
    wait_idle("resume_timeout");
    check("resume_sb", 32'(sb.size()), 32'd0);

    // Reset during data bit 5; write during reset is ignored
    wr = 1'b1; wdata = 8'h5A; push_exp(8'h5A);
    tick();
    wdata = 8'hC3; push_exp(8'hC3);
    tick();
    wr = 1'b0;
    repeat (25) tick();
    rst = 1'b1; wr = 1'b1; wdata = 8'h77;
    sb.delete();
    tick();
    rst = 1'b0; wr = 1'b0;
    check("mrst_txd_o", 32'(txd_o), 32'd1);
    check("mrst_txd_t", 32'(txd_t), 32'd1);
    check("mrst_busy",  32'(busy),  32'd0);
    check("mrst_empty", 32'(empty), 32'd1);
    n = 0;
    repeat (60) begin
      tick();
      if (txd_o !== 1'b1) n++;
    end
    check("mrst_quiet", 32'(n), 32'd0);
    check("final_sb", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
